// File: rtl/ls_queue.sv
// In-order load/store queue: snoops the ALU and LS CDBs, issues from head to memory, broadcasts load results.
// Optional LSQ_ALLOC_BYPASS_EN: capture same-cycle CDB values into operands at allocation.
module ls_queue #(
  parameter int LSQ_DEPTH = 8,
  parameter int ROB_TAG_W = 4,
  parameter int DATA_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 in_alloc_ena,
  input  logic                 in_alloc_is_store,
  input  logic [1:0]           in_alloc_width,
  input  logic                 in_alloc_signed,
  input  logic [ROB_TAG_W-1:0] in_alloc_rob_tag,
  input  logic [ROB_TAG_W-1:0] in_alloc_base_tag,
  input  logic [DATA_W-1:0]    in_alloc_base_value,
  input  logic [ROB_TAG_W-1:0] in_alloc_data_tag,
  input  logic [DATA_W-1:0]    in_alloc_data_value,
  input  logic [DATA_W-1:0]    in_alloc_offset,
  output logic                 out_full,
  input  logic [ROB_TAG_W-1:0] in_cdb_rob_tag,
  input  logic [DATA_W-1:0]    in_cdb_value,
  input  logic [ROB_TAG_W-1:0] in_committed_rob_tag,
  input  logic                 in_misbranch,
  output logic                 out_mem_req,
  output logic                 out_mem_we,
  output logic [DATA_W-1:0]    out_mem_addr,
  output logic [DATA_W-1:0]    out_mem_wdata,
  output logic [1:0]           out_mem_width,
  input  logic                 in_mem_ack,
  input  logic [DATA_W-1:0]    in_mem_rdata,
  output logic [ROB_TAG_W-1:0] out_ls_cdb_rob_tag,
  output logic [DATA_W-1:0]    out_ls_cdb_value
);

  localparam int PTR_W = $clog2(LSQ_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(LSQ_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, DRAIN} state_t;

  logic                 r_valid     [LSQ_DEPTH];
  logic                 r_isStore   [LSQ_DEPTH];
  logic [1:0]           r_width     [LSQ_DEPTH];
  logic                 r_signed    [LSQ_DEPTH];
  logic [ROB_TAG_W-1:0] r_robTag    [LSQ_DEPTH];
  logic [ROB_TAG_W-1:0] r_baseTag   [LSQ_DEPTH];
  logic [DATA_W-1:0]    r_baseVal   [LSQ_DEPTH];
  logic [ROB_TAG_W-1:0] r_dataTag   [LSQ_DEPTH];
  logic [DATA_W-1:0]    r_dataVal   [LSQ_DEPTH];
  logic [DATA_W-1:0]    r_offset    [LSQ_DEPTH];
  logic                 r_committed [LSQ_DEPTH];
  logic [PTR_W-1:0]     r_head, r_tail;
  logic [PTR_W:0]       r_count;
  state_t               r_state;

  logic                 w_valid     [LSQ_DEPTH];
  logic                 w_isStore   [LSQ_DEPTH];
  logic [1:0]           w_width     [LSQ_DEPTH];
  logic                 w_signed    [LSQ_DEPTH];
  logic [ROB_TAG_W-1:0] w_robTag    [LSQ_DEPTH];
  logic [ROB_TAG_W-1:0] w_baseTag   [LSQ_DEPTH];
  logic [DATA_W-1:0]    w_baseVal   [LSQ_DEPTH];
  logic [ROB_TAG_W-1:0] w_dataTag   [LSQ_DEPTH];
  logic [DATA_W-1:0]    w_dataVal   [LSQ_DEPTH];
  logic [DATA_W-1:0]    w_offset    [LSQ_DEPTH];
  logic                 w_committed [LSQ_DEPTH];
  logic [PTR_W-1:0]     w_head, w_tail, w_idx;
  logic [PTR_W:0]       w_count, w_prefix;
  logic                 w_run, w_deq, w_headIsLoad;
  state_t               w_state;
  logic                 w_memReq, w_memWe;
  logic [DATA_W-1:0]    w_memAddr, w_memWdata;
  logic [1:0]           w_memWidth;
  logic [ROB_TAG_W-1:0] w_cdbTag;
  logic [DATA_W-1:0]    w_cdbValue;

  assign out_full = (r_count == CNT_FULL);

  function automatic logic [DATA_W-1:0] extendLoad(input logic [1:0] width, input logic sgn,
                                                   input logic [DATA_W-1:0] d);
    case (width)
      2'b00:   extendLoad = {{(DATA_W-8){sgn & d[7]}}, d[7:0]};
      2'b01:   extendLoad = {{(DATA_W-16){sgn & d[15]}}, d[15:0]};
      default: extendLoad = d;
    endcase
  endfunction

  // Next-state ordering: snoop, commit, flush (keeps committed prefix), dequeue, then alloc.
  always_comb begin
    w_valid = r_valid; w_isStore = r_isStore; w_width = r_width; w_signed = r_signed;
    w_robTag = r_robTag; w_baseTag = r_baseTag; w_baseVal = r_baseVal;
    w_dataTag = r_dataTag; w_dataVal = r_dataVal; w_offset = r_offset;
    w_committed = r_committed;
    w_head = r_head; w_tail = r_tail; w_count = r_count; w_idx = r_head;
    w_prefix = '0; w_run = 1'b1;
    w_state = r_state;
    w_memReq = out_mem_req; w_memWe = out_mem_we; w_memAddr = out_mem_addr;
    w_memWdata = out_mem_wdata; w_memWidth = out_mem_width;
    w_cdbTag = '0; w_cdbValue = '0;
    w_deq = (r_state == WAIT_MEM) && in_mem_ack;
    w_headIsLoad = !r_isStore[r_head];

    for (int i = 0; i < LSQ_DEPTH; i++) begin
      if (r_valid[i]) begin
        if (in_cdb_rob_tag != '0 && r_baseTag[i] == in_cdb_rob_tag) begin
          w_baseTag[i] = '0; w_baseVal[i] = in_cdb_value;
        end else if (out_ls_cdb_rob_tag != '0 && r_baseTag[i] == out_ls_cdb_rob_tag) begin
          w_baseTag[i] = '0; w_baseVal[i] = out_ls_cdb_value;
        end
        if (in_cdb_rob_tag != '0 && r_dataTag[i] == in_cdb_rob_tag) begin
          w_dataTag[i] = '0; w_dataVal[i] = in_cdb_value;
        end else if (out_ls_cdb_rob_tag != '0 && r_dataTag[i] == out_ls_cdb_rob_tag) begin
          w_dataTag[i] = '0; w_dataVal[i] = out_ls_cdb_value;
        end
        if (in_committed_rob_tag != '0 && r_robTag[i] == in_committed_rob_tag)
          w_committed[i] = 1'b1;
      end
    end

    for (int i = 0; i < LSQ_DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if (w_run && w_valid[w_idx] && w_isStore[w_idx] && w_committed[w_idx])
        w_prefix = w_prefix + CNT_ONE;
      else
        w_run = 1'b0;
    end

    if (in_misbranch) begin
      for (int i = 0; i < LSQ_DEPTH; i++)
        if (!w_committed[i]) w_valid[i] = 1'b0;
      w_tail  = r_head + w_prefix[PTR_W-1:0];
      w_count = w_prefix;
    end

    // A flushed head load is already gone; its ack only releases the bus.
    if (w_deq && !(in_misbranch && w_headIsLoad)) begin
      w_valid[r_head] = 1'b0;
      w_head  = r_head + PTR_ONE;
      w_count = w_count - CNT_ONE;
    end

    if (in_alloc_ena && !out_full && !in_misbranch) begin
      w_valid[r_tail]     = 1'b1;
      w_isStore[r_tail]   = in_alloc_is_store;
      w_width[r_tail]     = in_alloc_width;
      w_signed[r_tail]    = in_alloc_signed;
      w_robTag[r_tail]    = in_alloc_rob_tag;
      w_baseTag[r_tail]   = in_alloc_base_tag;
      w_baseVal[r_tail]   = in_alloc_base_value;
      w_dataTag[r_tail]   = in_alloc_data_tag;
      w_dataVal[r_tail]   = in_alloc_data_value;
      w_offset[r_tail]    = in_alloc_offset;
      w_committed[r_tail] = 1'b0;
`ifdef LSQ_ALLOC_BYPASS_EN
      if (in_cdb_rob_tag != '0 && in_alloc_base_tag == in_cdb_rob_tag) begin
        w_baseTag[r_tail] = '0; w_baseVal[r_tail] = in_cdb_value;
      end else if (out_ls_cdb_rob_tag != '0 && in_alloc_base_tag == out_ls_cdb_rob_tag) begin
        w_baseTag[r_tail] = '0; w_baseVal[r_tail] = out_ls_cdb_value;
      end
      if (in_cdb_rob_tag != '0 && in_alloc_data_tag == in_cdb_rob_tag) begin
        w_dataTag[r_tail] = '0; w_dataVal[r_tail] = in_cdb_value;
      end else if (out_ls_cdb_rob_tag != '0 && in_alloc_data_tag == out_ls_cdb_rob_tag) begin
        w_dataTag[r_tail] = '0; w_dataVal[r_tail] = out_ls_cdb_value;
      end
`endif
      w_tail  = r_tail + PTR_ONE;
      w_count = w_count + CNT_ONE;
    end

    // Issue looks at the head as it will be after this edge, so the request register fills one cycle later.
    case (r_state)
      IDLE: begin
        if (w_valid[w_head] && w_baseTag[w_head] == '0 &&
            (!w_isStore[w_head] || (w_dataTag[w_head] == '0 && w_committed[w_head]))) begin
          w_state    = WAIT_MEM;
          w_memReq   = 1'b1;
          w_memWe    = w_isStore[w_head];
          w_memAddr  = w_baseVal[w_head] + w_offset[w_head];
          w_memWidth = w_width[w_head];
          if (w_isStore[w_head]) w_memWdata = w_dataVal[w_head];
        end
      end
      WAIT_MEM: begin
        if (in_mem_ack) begin
          w_state  = IDLE;
          w_memReq = 1'b0;
          if (w_headIsLoad && !in_misbranch) begin
            w_cdbTag   = r_robTag[r_head];
            w_cdbValue = extendLoad(r_width[r_head], r_signed[r_head], in_mem_rdata);
          end
        end else if (in_misbranch && w_headIsLoad) begin
          w_state = DRAIN;
        end
      end
      DRAIN: begin
        if (in_mem_ack) begin
          w_state  = IDLE;
          w_memReq = 1'b0;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LSQ_DEPTH; i++) begin
        r_valid[i] <= 1'b0; r_isStore[i] <= 1'b0; r_width[i] <= '0; r_signed[i] <= 1'b0;
        r_robTag[i] <= '0; r_baseTag[i] <= '0; r_baseVal[i] <= '0; r_dataTag[i] <= '0;
        r_dataVal[i] <= '0; r_offset[i] <= '0; r_committed[i] <= 1'b0;
      end
      r_head <= '0; r_tail <= '0; r_count <= '0;
      r_state <= IDLE;
      out_mem_req <= 1'b0; out_mem_we <= 1'b0; out_mem_addr <= '0;
      out_mem_wdata <= '0; out_mem_width <= '0;
      out_ls_cdb_rob_tag <= '0; out_ls_cdb_value <= '0;
    end else if (ena) begin
      r_valid <= w_valid; r_isStore <= w_isStore; r_width <= w_width; r_signed <= w_signed;
      r_robTag <= w_robTag; r_baseTag <= w_baseTag; r_baseVal <= w_baseVal;
      r_dataTag <= w_dataTag; r_dataVal <= w_dataVal; r_offset <= w_offset;
      r_committed <= w_committed;
      r_head <= w_head; r_tail <= w_tail; r_count <= w_count;
      r_state <= w_state;
      out_mem_req <= w_memReq; out_mem_we <= w_memWe; out_mem_addr <= w_memAddr;
      out_mem_wdata <= w_memWdata; out_mem_width <= w_memWidth;
      out_ls_cdb_rob_tag <= w_cdbTag; out_ls_cdb_value <= w_cdbValue;
    end
  end

endmodule

// File: tb/tb_ls_queue.sv
// Directed self-checking bench for ls_queue; expectations are hand-computed per step.
// Define LSQ_ALLOC_BYPASS_EN here and in the RTL build to exercise the allocation bypass.
module tb_ls_queue;

  logic        clk = 1'b0;
  logic        rst, ena;
  logic        in_alloc_ena, in_alloc_is_store, in_alloc_signed;
  logic [1:0]  in_alloc_width;
  logic [3:0]  in_alloc_rob_tag, in_alloc_base_tag, in_alloc_data_tag;
  logic [31:0] in_alloc_base_value, in_alloc_data_value, in_alloc_offset;
  logic        out_full;
  logic [3:0]  in_cdb_rob_tag, in_committed_rob_tag;
  logic [31:0] in_cdb_value;
  logic        in_misbranch;
  logic        out_mem_req, out_mem_we;
  logic [31:0] out_mem_addr, out_mem_wdata;
  logic [1:0]  out_mem_width;
  logic        in_mem_ack;
  logic [31:0] in_mem_rdata;
  logic [3:0]  out_ls_cdb_rob_tag;
  logic [31:0] out_ls_cdb_value;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ls_queue #(.LSQ_DEPTH(8), .ROB_TAG_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .in_alloc_ena(in_alloc_ena), .in_alloc_is_store(in_alloc_is_store),
    .in_alloc_width(in_alloc_width), .in_alloc_signed(in_alloc_signed),
    .in_alloc_rob_tag(in_alloc_rob_tag),
    .in_alloc_base_tag(in_alloc_base_tag), .in_alloc_base_value(in_alloc_base_value),
    .in_alloc_data_tag(in_alloc_data_tag), .in_alloc_data_value(in_alloc_data_value),
    .in_alloc_offset(in_alloc_offset), .out_full(out_full),
    .in_cdb_rob_tag(in_cdb_rob_tag), .in_cdb_value(in_cdb_value),
    .in_committed_rob_tag(in_committed_rob_tag), .in_misbranch(in_misbranch),
    .out_mem_req(out_mem_req), .out_mem_we(out_mem_we),
    .out_mem_addr(out_mem_addr), .out_mem_wdata(out_mem_wdata),
    .out_mem_width(out_mem_width), .in_mem_ack(in_mem_ack), .in_mem_rdata(in_mem_rdata),
    .out_ls_cdb_rob_tag(out_ls_cdb_rob_tag), .out_ls_cdb_value(out_ls_cdb_value)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic isStore, input logic [1:0] width, input logic sgn,
                               input logic [3:0] rob, input logic [3:0] bTag, input logic [31:0] bVal,
                               input logic [3:0] dTag, input logic [31:0] dVal, input logic [31:0] off);
    in_alloc_ena = 1'b1; in_alloc_is_store = isStore; in_alloc_width = width;
    in_alloc_signed = sgn; in_alloc_rob_tag = rob; in_alloc_base_tag = bTag;
    in_alloc_base_value = bVal; in_alloc_data_tag = dTag; in_alloc_data_value = dVal;
    in_alloc_offset = off;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1;
    in_alloc_ena = 0; in_alloc_is_store = 0; in_alloc_signed = 0; in_alloc_width = 0;
    in_alloc_rob_tag = 0; in_alloc_base_tag = 0; in_alloc_data_tag = 0;
    in_alloc_base_value = 0; in_alloc_data_value = 0; in_alloc_offset = 0;
    in_cdb_rob_tag = 0; in_cdb_value = 0; in_committed_rob_tag = 0; in_misbranch = 0;
    in_mem_ack = 0; in_mem_rdata = 0;
    tick(); tick();
    checkOutput("rstReq", 32'(out_mem_req), 32'h0);
    checkOutput("rstAddr", out_mem_addr, 32'h0);
    checkOutput("rstCdbTag", 32'(out_ls_cdb_rob_tag), 32'h0);
    checkOutput("rstFull", 32'(out_full), 32'h0);
    checkOutput("rstCount", 32'(dut.r_count), 32'h0);
    rst = 1'b0;
    tick();

    // Signed byte load, ready base.
    applyStimulus(1'b0, 2'b00, 1'b1, 4'd1, 4'd0, 32'h100, 4'd0, 32'h0, 32'h4);
    tick();
    in_alloc_ena = 1'b0;
    checkOutput("ldReq", 32'(out_mem_req), 32'h1);
    checkOutput("ldWe", 32'(out_mem_we), 32'h0);
    checkOutput("ldAddr", out_mem_addr, 32'h104);
    checkOutput("ldWidth", 32'(out_mem_width), 32'h0);
    in_mem_ack = 1'b1; in_mem_rdata = 32'h80;
    tick();
    in_mem_ack = 1'b0;
    checkOutput("ldReqDrop", 32'(out_mem_req), 32'h0);
    checkOutput("ldCdbTag", 32'(out_ls_cdb_rob_tag), 32'h1);
    checkOutput("ldCdbValue", out_ls_cdb_value, 32'hFFFFFF80);
    tick();
    checkOutput("ldCdbPulse", 32'(out_ls_cdb_rob_tag), 32'h0);

    // Store waits for its data and then for commit.
    applyStimulus(1'b1, 2'b10, 1'b0, 4'd2, 4'd0, 32'h200, 4'd5, 32'h0, 32'h0);
    tick();
    in_alloc_ena = 1'b0;
    checkOutput("stWaitData", 32'(out_mem_req), 32'h0);
    in_cdb_rob_tag = 4'd5; in_cdb_value = 32'hDEAD;
    tick();
    in_cdb_rob_tag = 4'd0;
    checkOutput("stWaitCommit", 32'(out_mem_req), 32'h0);
    tick();
    checkOutput("stStillWaiting", 32'(out_mem_req), 32'h0);
    in_committed_rob_tag = 4'd2;
    tick();
    in_committed_rob_tag = 4'd0;
    checkOutput("stReq", 32'(out_mem_req), 32'h1);
    checkOutput("stWe", 32'(out_mem_we), 32'h1);
    checkOutput("stWdata", out_mem_wdata, 32'hDEAD);
    checkOutput("stAddr", out_mem_addr, 32'h200);
    in_mem_ack = 1'b1;
    tick();
    in_mem_ack = 1'b0;
    checkOutput("stReqDrop", 32'(out_mem_req), 32'h0);
    checkOutput("stNoCdb", 32'(out_ls_cdb_rob_tag), 32'h0);

    // Fill from head index 2 so the pointers wrap past 7.
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 2'b10, 1'b0, 4'(k), 4'd7, 32'h0, 4'd0, 32'h0, 32'(k * 4));
      tick();
    end
    in_alloc_ena = 1'b0;
    checkOutput("fullFlag", 32'(out_full), 32'h1);
    checkOutput("fullCount", 32'(dut.r_count), 32'h8);
    applyStimulus(1'b0, 2'b10, 1'b0, 4'd9, 4'd0, 32'h900, 4'd0, 32'h0, 32'h0);
    tick();
    in_alloc_ena = 1'b0;
    checkOutput("ninthDropped", 32'(dut.r_count), 32'h8);
    checkOutput("fullNoReq", 32'(out_mem_req), 32'h0);
    in_cdb_rob_tag = 4'd7; in_cdb_value = 32'h300;
    tick();
    in_cdb_rob_tag = 4'd0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) tick();
      checkOutput("wrapReq", 32'(out_mem_req), 32'h1);
      checkOutput("wrapAddr", out_mem_addr, 32'h300 + 32'(k * 4));
      in_mem_ack = 1'b1; in_mem_rdata = 32'h1000 + 32'(k);
      tick();
      in_mem_ack = 1'b0;
      checkOutput("wrapCdbTag", 32'(out_ls_cdb_rob_tag), 32'(k));
      checkOutput("wrapCdbValue", out_ls_cdb_value, 32'h1000 + 32'(k));
      if (k == 1) checkOutput("notFullAfterAck", 32'(out_full), 32'h0);
    end
    tick();
    checkOutput("drainedNoReq", 32'(out_mem_req), 32'h0);
    checkOutput("drainedCount", 32'(dut.r_count), 32'h0);

    // Committed store survives a flush that removes two loads behind it.
    applyStimulus(1'b1, 2'b10, 1'b0, 4'd3, 4'd0, 32'h400, 4'd0, 32'h55, 32'h0);
    tick();
    applyStimulus(1'b0, 2'b10, 1'b0, 4'd4, 4'd9, 32'h0, 4'd0, 32'h0, 32'h0);
    tick();
    applyStimulus(1'b0, 2'b10, 1'b0, 4'd5, 4'd9, 32'h0, 4'd0, 32'h0, 32'h8);
    tick();
    in_alloc_ena = 1'b0;
    checkOutput("flushPreNoReq", 32'(out_mem_req), 32'h0);
    in_committed_rob_tag = 4'd3; in_misbranch = 1'b1;
    tick();
    in_committed_rob_tag = 4'd0; in_misbranch = 1'b0;
    checkOutput("flushStReq", 32'(out_mem_req), 32'h1);
    checkOutput("flushStWe", 32'(out_mem_we), 32'h1);
    checkOutput("flushStAddr", out_mem_addr, 32'h400);
    checkOutput("flushStWdata", out_mem_wdata, 32'h55);
    checkOutput("flushCount", 32'(dut.r_count), 32'h1);
    in_cdb_rob_tag = 4'd9; in_cdb_value = 32'h500; in_mem_ack = 1'b1;
    tick();
    in_cdb_rob_tag = 4'd0; in_mem_ack = 1'b0;
    checkOutput("flushStDone", 32'(out_mem_req), 32'h0);
    checkOutput("flushEmpty", 32'(dut.r_count), 32'h0);
    tick(); tick();
    checkOutput("flushedLoadsGone", 32'(out_mem_req), 32'h0);

    // Flush during an outstanding head load: drain, no broadcast.
    applyStimulus(1'b0, 2'b10, 1'b0, 4'd6, 4'd0, 32'h600, 4'd0, 32'h0, 32'h0);
    tick();
    in_alloc_ena = 1'b0;
    checkOutput("drainReq", 32'(out_mem_req), 32'h1);
    in_misbranch = 1'b1;
    tick();
    in_misbranch = 1'b0;
    checkOutput("drainHeld", 32'(out_mem_req), 32'h1);
    checkOutput("drainAddr", out_mem_addr, 32'h600);
    tick();
    checkOutput("drainHeld2", 32'(out_mem_req), 32'h1);
    in_mem_ack = 1'b1; in_mem_rdata = 32'h77;
    tick();
    in_mem_ack = 1'b0;
    checkOutput("drainReqDrop", 32'(out_mem_req), 32'h0);
    checkOutput("drainNoCdb", 32'(out_ls_cdb_rob_tag), 32'h0);
    applyStimulus(1'b0, 2'b10, 1'b0, 4'd7, 4'd0, 32'h700, 4'd0, 32'h0, 32'h0);
    tick();
    in_alloc_ena = 1'b0;
    checkOutput("idleAgainReq", 32'(out_mem_req), 32'h1);
    checkOutput("idleAgainAddr", out_mem_addr, 32'h700);
    in_mem_ack = 1'b1; in_mem_rdata = 32'h1234;
    tick();
    in_mem_ack = 1'b0;
    checkOutput("idleAgainCdb", 32'(out_ls_cdb_rob_tag), 32'h7);

    // Producer broadcasts in the allocation cycle.
    applyStimulus(1'b0, 2'b10, 1'b0, 4'd8, 4'd3, 32'h0, 4'd0, 32'h0, 32'h10);
    in_cdb_rob_tag = 4'd3; in_cdb_value = 32'h40;
    tick();
    in_alloc_ena = 1'b0; in_cdb_rob_tag = 4'd0;
`ifdef LSQ_ALLOC_BYPASS_EN
    checkOutput("bypassReq", 32'(out_mem_req), 32'h1);
    checkOutput("bypassAddr", out_mem_addr, 32'h50);
`else
    checkOutput("noBypassWait", 32'(out_mem_req), 32'h0);
    tick();
    checkOutput("noBypassWait2", 32'(out_mem_req), 32'h0);
    in_cdb_rob_tag = 4'd3; in_cdb_value = 32'h60;
    tick();
    in_cdb_rob_tag = 4'd0;
    checkOutput("lateSnoopReq", 32'(out_mem_req), 32'h1);
    checkOutput("lateSnoopAddr", out_mem_addr, 32'h70);
`endif
    in_mem_ack = 1'b1; in_mem_rdata = 32'hABCD;
    tick();
    in_mem_ack = 1'b0;
    checkOutput("bypassCdbTag", 32'(out_ls_cdb_rob_tag), 32'h8);
    checkOutput("bypassCdbValue", out_ls_cdb_value, 32'hABCD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ls_queue.md
# ls_queue

In-order load/store queue on the receive side of the reorder buffer's store-commit and load-writeback protocol. Accepts memory ops from the decoder and resolves their operand tags by snooping the ALU CDB. Issues loads and committed stores to the memory controller over a request/ack handshake. Broadcasts load results on the dedicated LS CDB that the ROB and reservation stations consume.

## Interface
- LSQ_DEPTH, 8, entry count (power of two, ≥2)
- ROB_TAG_W, 4, ROB tag width; tag 0 means "none / ready"
- DATA_W, 32, data and address width

Reset rst, synchronous, active-high; clock clk.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ena  in  1  global stall; when low, all state holds and outputs hold
- in_alloc_ena  in  1  allocate one entry this cycle
- in_alloc_is_store  in  1  1 = store, 0 = load
- in_alloc_width  in  2  00 byte, 01 half, 10 word
- in_alloc_signed  in  1  sign-extend load result
- in_alloc_rob_tag  in  ROB_TAG_W  owning ROB entry
- in_alloc_base_tag / in_alloc_base_value  in  ROB_TAG_W / DATA_W  base register operand
- in_alloc_data_tag / in_alloc_data_value  in  ROB_TAG_W / DATA_W  store data operand
- in_alloc_offset  in  DATA_W  sign-extended immediate
- out_full  out  1  count == LSQ_DEPTH (combinational)
- in_cdb_rob_tag / in_cdb_value  in  ROB_TAG_W / DATA_W  ALU CDB snoop
- in_committed_rob_tag  in  ROB_TAG_W  store committed by ROB (0 = none)
- in_misbranch  in  1  flush speculative entries
- out_mem_req, out_mem_we  out  1  request valid, write
- out_mem_addr, out_mem_wdata  out  DATA_W
- out_mem_width  out  2
- in_mem_ack  in  1  one-cycle completion pulse
- in_mem_rdata  in  DATA_W  right-aligned load data, valid with ack
- out_ls_cdb_rob_tag / out_ls_cdb_value  out  ROB_TAG_W / DATA_W  load writeback

## Operation
- Circular buffer: head, tail, count. Alloc writes at tail when !out_full; alloc while full is dropped.
- Each entry holds: valid, is_store, width, signed, rob_tag, base tag/value, data tag/value, offset, committed.
- Snoop: every cycle, any valid entry whose base_tag or data_tag equals nonzero in_cdb_rob_tag or out_ls_cdb_rob_tag captures that value and clears the tag to 0.
- Commit: entry with rob_tag == nonzero in_committed_rob_tag sets committed.
- Issue is from head only. Load is ready when base_tag == 0. Store is ready when base_tag == 0, data_tag == 0 and committed.
- Address = base_value + offset, modulo 2^DATA_W.
- FSM IDLE → WAIT_MEM when head is ready. Load request: out_mem_we 0. Store request: out_mem_we 1 and wdata = data_value.
- WAIT_MEM → IDLE on in_mem_ack: entry dequeues. On a load, the result is extended per width/signed (byte bit 7, half bit 15) and broadcast.
- Flush on in_misbranch: all non-committed entries invalidated. Committed stores form a prefix from head and survive; tail = head + committed count.
- Flush while a head load is in WAIT_MEM: go to DRAIN. Hold the request until ack, discard data, no broadcast, then IDLE.
- Same cycle: commit is applied before flush, so the matching store survives. Flush beats alloc, so alloc is dropped. Ack + dequeue + alloc is legal and count is unchanged.

## Timing
- Reset values: out_mem_req/we/addr/wdata/width = 0; out_ls_cdb_rob_tag/value = 0; out_full = 0; head = tail = count = 0; FSM IDLE.
- Allocated entry is visible for issue the next cycle. Request is registered: asserted the cycle after head becomes ready.
- Request fields stay stable until the cycle after ack. The next request is no earlier than 1 cycle after ack.
- LS CDB is registered: a 1-cycle pulse on the cycle after load ack; otherwise the tag is 0.
- Minimum load latency from alloc (ready operands, 1-cycle memory): alloc N, req N+1, ack N+1, broadcast N+2.

## Configuration
- LSQ_ALLOC_BYPASS_EN defined: at alloc, an operand tag equal to the same-cycle nonzero CDB tag (either bus) captures that value and is stored ready.
- LSQ_ALLOC_BYPASS_EN undefined: no capture at alloc. The producer must not broadcast in the allocation cycle; the decoder guarantees this by ROB readback.

## Test plan
- Load with ready base 0x100 and offset 4, byte, signed; memory returns 0x80 → req addr 0x104, width 00; LS CDB tag = rob_tag, value 0xFFFFFF80 one cycle after ack.
- Store with data_tag 5, then CDB tag 5 value 0xDEAD → no request until in_committed_rob_tag equals the store's tag; then we=1, wdata 0xDEAD.
- Fill 8 entries → out_full=1 and a 9th alloc is ignored; one ack → out_full=0 the next cycle; head/tail wrap past index 7 correctly.
- Committed store at head, two speculative loads behind it, misbranch → store still issues; loads are never requested; count=0 after the store ack.
- Head load in WAIT_MEM plus misbranch → request held until ack; no LS CDB pulse; FSM returns to IDLE.
- With the macro defined, alloc base_tag 3 while CDB tag 3 value 0x40 → load issues the next cycle with addr 0x40+offset; without the macro, the entry waits.
